alu_seq_nbit: RTL and testbench
===============================

# alu_seq_nbit

Parametrised, registered N-bit ALU with a valid/ready handshake on input and output and an iterative signed multiply. Next-generation replacement for the combinational 4-bit ALU in the datapath. Keeps the same 3-bit operation encoding and the Zero/Overflow flags, fills the spare opcode 101 with MUL, and fixes SLT so it is correct under subtract overflow.

## Interface
- WIDTH, 4: operand/result width in bits, ≥ 2.
- MUL_EN, 1: 1 = opcode 101 performs multiply; 0 = opcode 101 is reserved.
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high; forces IDLE and clears all registered outputs.
- In_valid  in  1  operands and opcode are presented.
- In_ready  out  1  block accepts the operation this cycle; forced 0 while Reset is high.
- A  in  WIDTH  signed operand A.
- B  in  WIDTH  signed operand B.
- Operation  in  3  opcode: 000 AND, 001 OR, 010 ADD, 011 NAND, 100 NOR, 101 MUL, 110 SUB, 111 SLT.
- Out_valid  out  1  Result and flags are valid.
- Out_ready  in  1  consumer takes the result this cycle.
- Result  out  WIDTH  registered signed result.
- Zero  out  1  registered; Result == 0.
- Overflow  out  1  registered signed-overflow flag.

## Operation
- **Accept rule.** An operation is accepted on a rising edge with In_valid & In_ready.
  - A, B and Operation are captured at that edge; later input changes have no effect.
- **States.** IDLE, MUL, HOLD.
  - IDLE: In_ready = 1.
  - MUL: In_ready = 0.
  - HOLD: Out_valid = 1; In_ready = Out_ready.
- **Transitions.**
  - IDLE + accept of a single-cycle op → HOLD, with Result and flags loaded.
  - IDLE + accept of MUL (MUL_EN = 1) → MUL.
  - MUL, after WIDTH iterations → HOLD.
  - HOLD & Out_ready & In_valid → accept the next op: single-cycle op → HOLD with new data; MUL → MUL.
  - HOLD & Out_ready & !In_valid → IDLE.
  - HOLD & !Out_ready → HOLD; Result and flags stay stable.
- **Logic ops.** Bitwise, full WIDTH; Overflow = 0.
- **ADD / SUB.** WIDTH-bit wrap-around. Overflow = operand signs (B inverted for SUB) agree and the result sign differs.
- **SLT.** Result = 1 if A < B as signed, else 0. Computed as sign(A−B) XOR overflow(A−B). Overflow flag = overflow(A−B).
- **MUL.** Signed WIDTH×WIDTH multiply, radix-2 shift-add on operand magnitudes into a 2·WIDTH accumulator, sign-corrected on completion.
  - Result = low WIDTH bits of the product.
  - Overflow = the 2·WIDTH product does not sign-fit in WIDTH bits.
- **Opcode 101 with MUL_EN = 0.** Single-cycle: Result = 0, Zero = 1, Overflow = 0.
- **Zero.** Always computed from the Result value being registered.
- **Reset, including mid-multiply.** Aborts any operation; State = IDLE. Out_valid = 0, Result = 0, Zero = 0, Overflow = 0; accumulator and counter cleared.

## Timing
- **Single-cycle ops.** Out_valid rises on the acceptance edge (latency 1). Throughput is 1 op/cycle when Out_ready is held high.
- **MUL.** Out_valid rises on the WIDTH-th edge after the acceptance edge. In_ready is 0 for those WIDTH−1 intermediate cycles.
- **Combinational path.** Out_ready → In_ready is the only one; there is no path from A/B to any output.
- **Hold behaviour.** With Out_valid = 1 and Out_ready = 0, all outputs hold indefinitely.
- **Flag validity.** Outputs are meaningful only while Out_valid = 1.

## Structure
- Package alu_pkg holds:
  - opcode localparams OP_AND, OP_OR, OP_ADD, OP_NAND, OP_NOR, OP_MUL, OP_SUB, OP_SLT;
  - the state enum IDLE/MUL/HOLD.
- Sub-module alu_mul_seq: iterative multiplier with start/done, WIDTH-bit counter, 2·WIDTH accumulator and overflow output.
- Top level contains the combinational logic/add/sub core, the FSM and the output registers.

## Test plan
- WIDTH=4, ADD 0111+0001 → Result 1000, Overflow 1, Zero 0; Out_valid on the acceptance edge.
- WIDTH=4, SLT 1101(−3) vs 0110(6) → Result 0001, Overflow 1, Zero 0. SLT 0101 vs 0001 → Result 0000, Zero 1.
- WIDTH=4, MUL cases; each must show In_ready low for 3 cycles and Out_valid exactly 4 edges after acceptance:
  - 0011×1110 → 1010(−6), Overflow 0.
  - 0111×0011 → 0101, Overflow 1.
  - 1000×1111 → 1000, Overflow 1.
- Backpressure: NOR 0101,0010 then Out_ready low for 3 cycles → Result 1000 held and In_ready 0. Then Out_ready high with AND 0111,0010 presented → accepted the same cycle, Result 0010 next edge.
- Reset asserted mid-multiply (second iteration) → Out_valid/Result/Zero/Overflow all 0 immediately. After release, In_ready = 1; OR 0101,0010 → 0111.
- WIDTH=8, MUL_EN=0:
  - SUB 0x80−0x01 → 0x7F, Overflow 1.
  - Opcode 101 → Result 0x00, Zero 1.
  - 10 back-to-back ADDs with Out_ready high → one result per cycle, none dropped.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU.
// - OP_* : 3-bit opcode encodings carried on the operation bus.
// - state_t : control FSM states (IDLE / MUL / HOLD).
package alu_pkg;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_nbit_if.sv
// Handshake bus between an ALU producer/consumer and the ALU.
// Input side : in_valid, in_ready, a, b, op
// Output side: out_valid, out_ready, result, zero, overflow
// master = the client driving operands and taking results; slave = the ALU.
interface alu_seq_nbit_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             overflow;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, zero, overflow
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, zero, overflow
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative signed multiplier: radix-2 shift-add over operand magnitudes,
// one multiplier bit per clock, sign applied on the final iteration.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (aborts and clears)
//   start_i      : load a_i/b_i and begin; takes WIDTH further clocks
//   a_i, b_i     : signed operands
//   done_o       : high in the cycle whose closing edge completes the product
//   product_o    : low WIDTH bits of the signed product (valid with done_o)
//   overflow_o   : signed product does not fit in WIDTH bits (valid with done_o)
module alu_mul_seq #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o,
    output logic             overflow_o
);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   cnt_q;
    logic               busy_q;
    logic               neg_q;

    logic [2*WIDTH-1:0] add_term;
    logic [2*WIDTH-1:0] acc_d;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    // Magnitude of the most negative value wraps to itself, which is the
    // correct unsigned magnitude 2^(WIDTH-1).
    assign mag_a = a_i[WIDTH-1] ? (~a_i + 1'b1) : a_i;
    assign mag_b = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;

    assign add_term    = mplier_q[0] ? ({{WIDTH{1'b0}}, mcand_q} << cnt_q) : '0;
    assign acc_d       = acc_q + add_term;
    assign prod_signed = neg_q ? (~acc_d + 1'b1) : acc_d;

    assign done_o     = busy_q && (cnt_q == LAST);
    assign product_o  = prod_signed[WIDTH-1:0];
    // Fits iff the top WIDTH+1 bits are a pure sign extension.
    assign overflow_o = !((&prod_signed[2*WIDTH-1:WIDTH-1]) ||
                          (~|prod_signed[2*WIDTH-1:WIDTH-1]));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            neg_q    <= 1'b0;
        end else if (start_i) begin
            acc_q    <= '0;
            mcand_q  <= mag_a;
            mplier_q <= mag_b;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            neg_q    <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
        end else if (busy_q) begin
            acc_q    <= acc_d;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done_o) begin
                busy_q <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/alu_seq_nbit.sv
// Registered N-bit ALU with valid/ready handshake on both sides.
// Single-cycle ops land in the output registers on the accept edge; MUL runs
// through alu_mul_seq and lands WIDTH edges after acceptance.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : alu_seq_nbit_if slave (operands/opcode in, result/flags out)
module alu_seq_nbit
    import alu_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int MUL_EN = 1
) (
    input  logic               clk,
    input  logic               rst,
    alu_seq_nbit_if.slave      bus
);
    state_t           state_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             overflow_q;

    logic             accept;
    logic             is_mul;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic             mul_ovf;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    // Out_ready -> in_ready is the only combinational path through the block.
    assign bus.in_ready  = !rst && ((state_q == IDLE) ||
                                    ((state_q == HOLD) && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign is_mul        = (MUL_EN != 0) && (bus.op == OP_MUL);
    assign mul_start     = accept && is_mul;

    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.overflow  = overflow_q;

    assign sum     = bus.a + bus.b;
    assign diff    = bus.a + ~bus.b + 1'b1;
    assign add_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
    assign sub_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (diff[WIDTH-1] != bus.a[WIDTH-1]);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (bus.op)
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_ADD:  begin alu_res = sum;  alu_ovf = add_ovf; end
            OP_NAND: alu_res = ~(bus.a & bus.b);
            OP_NOR:  alu_res = ~(bus.a | bus.b);
            OP_SUB:  begin alu_res = diff; alu_ovf = sub_ovf; end
            // Sign of A-B corrected by its overflow gives a true signed compare.
            OP_SLT:  begin
                alu_res = {{(WIDTH-1){1'b0}}, diff[WIDTH-1] ^ sub_ovf};
                alu_ovf = sub_ovf;
            end
            default: begin alu_res = '0; alu_ovf = 1'b0; end
        endcase
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .rst        (rst),
        .start_i    (mul_start),
        .a_i        (bus.a),
        .b_i        (bus.b),
        .done_o     (mul_done),
        .product_o  (mul_prod),
        .overflow_o (mul_ovf)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (accept) begin
            // Accept is only possible from IDLE or from HOLD with out_ready.
            if (is_mul) begin
                state_q     <= MUL;
                out_valid_q <= 1'b0;
            end else begin
                state_q     <= HOLD;
                out_valid_q <= 1'b1;
                result_q    <= alu_res;
                zero_q      <= (alu_res == '0);
                overflow_q  <= alu_ovf;
            end
        end else begin
            case (state_q)
                MUL: begin
                    if (mul_done) begin
                        state_q     <= HOLD;
                        out_valid_q <= 1'b1;
                        result_q    <= mul_prod;
                        zero_q      <= (mul_prod == '0);
                        overflow_q  <= mul_ovf;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                IDLE: ;
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_nbit.sv
module tb_alu_seq_nbit;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst4 = 1'b1;
    logic rst8 = 1'b1;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    alu_seq_nbit_if #(.WIDTH(4)) b4 ();
    alu_seq_nbit_if #(.WIDTH(8)) b8 ();

    alu_seq_nbit #(.WIDTH(4), .MUL_EN(1)) dut4 (.clk(clk), .rst(rst4), .bus(b4));
    alu_seq_nbit #(.WIDTH(8), .MUL_EN(0)) dut8 (.clk(clk), .rst(rst8), .bus(b8));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
            $display("check %-14s got %0h exp %0h ok", tag, got, exp);
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one op on the 4-bit bus for exactly one rising edge.
    task automatic drive4(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        b4.op = op; b4.a = a; b4.b = b; b4.in_valid = 1'b1;
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
    endtask

    task automatic drive8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        b8.op = op; b8.a = a; b8.b = b; b8.in_valid = 1'b1;
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
    endtask

    task automatic mul4(input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] er, input logic eo, input string nm);
        drive4(OP_MUL, a, b);
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk); #1;
            check({nm, "_rdy_lo"}, b4.in_ready, 0);
            check({nm, "_vld_lo"}, b4.out_valid, 0);
        end
        @(posedge clk); #1;
        check({nm, "_vld"}, b4.out_valid, 1);
        check({nm, "_res"}, b4.result, er);
        check({nm, "_ovf"}, b4.overflow, eo);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] a8, b8v;
        int s;
        b4.in_valid = 0; b4.a = 0; b4.b = 0; b4.op = 0; b4.out_ready = 0;
        b8.in_valid = 0; b8.a = 0; b8.b = 0; b8.op = 0; b8.out_ready = 0;

        // ---- WIDTH=4 reset state ----
        #3;
        check("rst_vld", b4.out_valid, 0);
        check("rst_res", b4.result, 0);
        check("rst_zero", b4.zero, 0);
        check("rst_ovf", b4.overflow, 0);
        check("rst_rdy", b4.in_ready, 0);
        #9 rst4 = 1'b0;
        b4.out_ready = 1'b1;
        #1 check("idle_rdy", b4.in_ready, 1);
        @(posedge clk); #1;

        // ADD overflow, result visible on the acceptance edge
        drive4(OP_ADD, 4'b0111, 4'b0001);
        check("add_vld", b4.out_valid, 1);
        check("add_res", b4.result, 4'b1000);
        check("add_ovf", b4.overflow, 1);
        check("add_zero", b4.zero, 0);

        // SLT across subtract overflow
        drive4(OP_SLT, 4'b1101, 4'b0110);
        check("slt1_res", b4.result, 4'b0001);
        check("slt1_ovf", b4.overflow, 1);
        check("slt1_zero", b4.zero, 0);
        drive4(OP_SLT, 4'b0101, 4'b0001);
        check("slt2_res", b4.result, 4'b0000);
        check("slt2_zero", b4.zero, 1);
        check("slt2_ovf", b4.overflow, 0);

        // Multiplies
        mul4(4'b0011, 4'b1110, 4'b1010, 1'b0, "mul_3xm2");
        mul4(4'b0111, 4'b0011, 4'b0101, 1'b1, "mul_7x3");
        mul4(4'b1000, 4'b1111, 4'b1000, 1'b1, "mul_m8xm1");

        // Backpressure
        drive4(OP_NOR, 4'b0101, 4'b0010);
        check("nor_res", b4.result, 4'b1000);
        b4.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_res", b4.result, 4'b1000);
            check("bp_vld", b4.out_valid, 1);
            check("bp_rdy", b4.in_ready, 0);
        end
        b4.out_ready = 1'b1;
        b4.op = OP_AND; b4.a = 4'b0111; b4.b = 4'b0010; b4.in_valid = 1'b1;
        #1 check("bp_rdy_hi", b4.in_ready, 1);
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        check("and_res", b4.result, 4'b0010);
        check("and_vld", b4.out_valid, 1);

        // Reset during the second multiply iteration
        drive4(OP_MUL, 4'b0011, 4'b0011);
        @(posedge clk); #1;
        rst4 = 1'b1;
        #1;
        check("mrst_vld", b4.out_valid, 0);
        check("mrst_res", b4.result, 0);
        check("mrst_zero", b4.zero, 0);
        check("mrst_ovf", b4.overflow, 0);
        @(negedge clk);
        rst4 = 1'b0;
        #1;
        check("mrst_rdy", b4.in_ready, 1);
        check("mrst_vld2", b4.out_valid, 0);
        drive4(OP_OR, 4'b0101, 4'b0010);
        check("or_res", b4.result, 4'b0111);
        check("or_vld", b4.out_valid, 1);

        // ---- WIDTH=8, MUL_EN=0 ----
        check("r8_vld", b8.out_valid, 0);
        check("r8_res", b8.result, 0);
        check("r8_rdy", b8.in_ready, 0);
        @(negedge clk);
        rst8 = 1'b0;
        b8.out_ready = 1'b1;
        #1;
        drive8(OP_SUB, 8'h80, 8'h01);
        check("sub8_res", b8.result, 8'h7F);
        check("sub8_ovf", b8.overflow, 1);
        drive8(OP_MUL, 8'h12, 8'h34);
        check("op5_vld", b8.out_valid, 1);
        check("op5_res", b8.result, 8'h00);
        check("op5_zero", b8.zero, 1);
        check("op5_ovf", b8.overflow, 0);

        // Ten back-to-back ADDs, one result per edge
        b8.op = OP_ADD;
        for (int i = 0; i < 10; i++) begin
            a8  = 8'(i * 29 + 100);
            b8v = 8'(i * 13 + 5);
            b8.a = a8; b8.b = b8v; b8.in_valid = 1'b1;
            @(posedge clk); #1;
            s = int'($signed(a8)) + int'($signed(b8v));
            check("b2b_vld", b8.out_valid, 1);
            check("b2b_res", b8.result, 8'(a8 + b8v));
            check("b2b_ovf", b8.overflow, (s > 127 || s < -128) ? 1 : 0);
        end
        b8.in_valid = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
